// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Bits needed to hold any value in 0..value-1; used as clog2(N+1) for the digit counter.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit.sv
// Combinational DIGIT-bit unsigned comparator (module mag_cmp_digit).
module mag_cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned.
// Optional macro SERIAL_CMP_EARLY_TERM_EN: finish on the first unequal digit.
//
// state | meaning
// IDLE  | waiting for start, results held from the last compare
// RUN   | comparing one digit per cycle, busy high
// DONE  | one-cycle result-valid pulse; start here begins a new compare
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             xgty,
    output logic             xlty,
    output logic             xeqy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N + 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    cmp_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic             xgty_q, xgty_d;
    logic             xlty_q, xlty_d;
    logic             xeqy_q, xeqy_d;

    logic dig_gt, dig_lt, dig_eq;
    logic accept, decided, last_dig, early_stop;

    mag_cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (xs_q[WIDTH-1 -: DIGIT]),
        .b  (ys_q[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    assign accept   = start && (state_q != RUN);
    assign decided  = xgty_q | xlty_q;
    assign last_dig = (cnt_q == CW'(1));

`ifdef SERIAL_CMP_EARLY_TERM_EN
    assign early_stop = !decided && !dig_eq;
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_dig || early_stop) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Inverting both MSBs for signed operands lets the unsigned digit compare give the signed order.
    always_comb begin
        cnt_d  = cnt_q;
        xs_d   = xs_q;
        ys_d   = ys_q;
        xgty_d = xgty_q;
        xlty_d = xlty_q;
        xeqy_d = xeqy_q;
        if (accept) begin
            xs_d   = is_signed ? (x ^ MSB_MASK) : x;
            ys_d   = is_signed ? (y ^ MSB_MASK) : y;
            cnt_d  = CW'(N);
            xgty_d = 1'b0;
            xlty_d = 1'b0;
            xeqy_d = 1'b0;
        end else if (state_q == RUN) begin
            xs_d  = xs_q << DIGIT;
            ys_d  = ys_q << DIGIT;
            cnt_d = cnt_q - CW'(1);
            if (!decided) begin
                xgty_d = dig_gt;
                xlty_d = dig_lt;
                xeqy_d = last_dig && dig_eq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            xs_q   <= '0;
            ys_q   <= '0;
            xgty_q <= 1'b0;
            xlty_q <= 1'b0;
            xeqy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            xs_q   <= xs_d;
            ys_q   <= ys_d;
            xgty_q <= xgty_d;
            xlty_q <= xlty_d;
            xeqy_q <= xeqy_d;
        end
    end

    assign xgty = xgty_q;
    assign xlty = xlty_q;
    assign xeqy = xeqy_q;

endmodule
